mux_out_glitch_filter: RTL and testbench

//  Downstream stage of the 2:1 select mux (ternary_operator_mux). Synchronises its asynchronous y output to clk.

---
 rtl/mux_out_glitch_filter.sv | 172 +++++++++++++++++
 tb/tb_mux_out_glitch_filter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_out_glitch_filter.sv
// mux_out_glitch_filter
//   Downstream stage of the 2:1 select mux. Synchronises the asynchronous mux output to clk,
//   rejects pulses shorter than STABLE_CYCLES clocks and presents a clean registered level
//   with one-cycle rise/fall strobes. Committed transitions are counted (saturating).
//
// Parameters
//   STABLE_CYCLES : clocks a new synced level must hold before it is committed (>= 2)
//   CNT_W         : width of edge_cnt / glitch_cnt
//
// Ports
//   clk        : clock, rising edge
//   reset      : asynchronous active-high reset
//   en         : filter enable; when low the qualifier is held idle and y_filt holds
//   y_in       : raw mux output, asynchronous to clk
//   cnt_clr    : synchronous clear of the counters (wins over a same-cycle increment)
//   y_filt     : filtered level (registered)
//   rise, fall : one-cycle strobes in the first cycle y_filt shows its new value
//   edge_cnt   : committed transitions, saturating at all-ones
//   glitch_cnt : rejected pulses, saturating; present only with MUX_FILT_GLITCH_CNT_EN
//
// Configuration
//   `define MUX_FILT_GLITCH_CNT_EN adds the glitch_cnt port and its counter.

module mux_out_glitch_filter #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             y_in,
  input  logic             cnt_clr,
  output logic             y_filt,
  output logic             rise,
  output logic             fall,
  output logic [CNT_W-1:0] edge_cnt
`ifdef MUX_FILT_GLITCH_CNT_EN
  ,
  output logic [CNT_W-1:0] glitch_cnt
`endif
);

  localparam int unsigned StabW = $clog2(STABLE_CYCLES);
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  typedef enum logic {StStable, StQualify} state_e;

  logic             s1_q, y_s_q;
  state_e           state_q, state_d;
  logic [StabW-1:0] stab_cnt_q, stab_cnt_d;
  logic             y_filt_q, y_filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             commit, glitch;

  // Two-flop synchroniser; free-running regardless of en.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      y_s_q <= 1'b0;
    end else begin
      s1_q  <= y_in;
      y_s_q <= s1_q;
    end
  end

  // Qualifier: a differing synced level must survive STABLE_CYCLES-1 further checks.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = stab_cnt_q;
    y_filt_d   = y_filt_q;
    commit     = 1'b0;
    glitch     = 1'b0;
    if (!en) begin
      // Disabling aborts any pending qualification without counting a glitch.
      state_d    = StStable;
      stab_cnt_d = '0;
    end else begin
      unique case (state_q)
        StStable: begin
          if (y_s_q != y_filt_q) begin
            state_d    = StQualify;
            stab_cnt_d = StabW'(1);
          end else begin
            stab_cnt_d = '0;
          end
        end
        StQualify: begin
          if (y_s_q == y_filt_q) begin
            state_d    = StStable;
            stab_cnt_d = '0;
            glitch     = 1'b1;
          end else if (stab_cnt_q == StabLast) begin
            y_filt_d   = y_s_q;
            state_d    = StStable;
            stab_cnt_d = '0;
            commit     = 1'b1;
          end else begin
            stab_cnt_d = stab_cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Strobes are registered alongside y_filt so they line up with its new value.
  always_comb begin
    rise_d = commit & y_s_q;
    fall_d = commit & ~y_s_q;
  end

  always_comb begin
    edge_cnt_d = edge_cnt_q;
    if (cnt_clr) begin
      edge_cnt_d = '0;
    end else if (commit && (edge_cnt_q != CntMax)) begin
      edge_cnt_d = edge_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StStable;
      stab_cnt_q <= '0;
      y_filt_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
      y_filt_q   <= y_filt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign y_filt   = y_filt_q;
  assign rise     = rise_q;
  assign fall     = fall_q;
  assign edge_cnt = edge_cnt_q;

`ifdef MUX_FILT_GLITCH_CNT_EN
  logic [CNT_W-1:0] glitch_cnt_q, glitch_cnt_d;

  always_comb begin
    glitch_cnt_d = glitch_cnt_q;
    if (cnt_clr) begin
      glitch_cnt_d = '0;
    end else if (glitch && (glitch_cnt_q != CntMax)) begin
      glitch_cnt_d = glitch_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      glitch_cnt_q <= '0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt = glitch_cnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch;
`endif

endmodule

// File: tb/tb_mux_out_glitch_filter.sv
// Directed bench for mux_out_glitch_filter (STABLE_CYCLES=4, CNT_W=8, 10 ns clock).
// Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the edge.

module tb_mux_out_glitch_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       y_in;
  logic       cnt_clr;
  logic       y_filt;
  logic       rise;
  logic       fall;
  logic [7:0] edge_cnt;
`ifdef MUX_FILT_GLITCH_CNT_EN
  logic [7:0] glitch_cnt;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  mux_out_glitch_filter #(
    .STABLE_CYCLES(4),
    .CNT_W        (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .y_in      (y_in),
    .cnt_clr   (cnt_clr),
    .y_filt    (y_filt),
    .rise      (rise),
    .fall      (fall),
    .edge_cnt  (edge_cnt)
`ifdef MUX_FILT_GLITCH_CNT_EN
    ,
    .glitch_cnt(glitch_cnt)
`endif
  );

  typedef struct {
    logic       y;
    logic       exp_filt;
    logic       exp_rise;
    logic       exp_fall;
    logic [7:0] exp_edge;
    logic [7:0] exp_glitch;
  } vec_t;

  vec_t tbl [20];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic f, input logic r, input logic fl,
                         input logic [7:0] e);
    chk({tag, " y_filt"}, {7'd0, y_filt}, {7'd0, f});
    chk({tag, " rise"}, {7'd0, rise}, {7'd0, r});
    chk({tag, " fall"}, {7'd0, fall}, {7'd0, fl});
    chk({tag, " edge_cnt"}, edge_cnt, e);
  endtask

  task automatic chk_glitch(input string tag, input logic [7:0] g);
`ifdef MUX_FILT_GLITCH_CNT_EN
    chk({tag, " glitch_cnt"}, glitch_cnt, g);
`else
    if (g === 8'hxx) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       y;
    logic [7:0] model;

    // Tests 1 and 2: rise after reset release, fall, then a one-cycle glitch.
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 8'd0};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'd1, 8'd0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'd1, 8'd0};
    tbl[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 8'd2, 8'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0};
    tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0};
    tbl[16] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd0};
    tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1};
    tbl[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1};
    tbl[19] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'd2, 8'd1};

    reset   = 1'b0;
    en      = 1'b1;
    y_in    = 1'b1;
    cnt_clr = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk_out("t1 reset", 1'b0, 1'b0, 1'b0, 8'd0);
    chk_glitch("t1 reset", 8'd0);
    tick();
    tick();
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      y_in = tbl[i].y;
      tick();
      chk_out($sformatf("t12 row%0d", i), tbl[i].exp_filt, tbl[i].exp_rise, tbl[i].exp_fall,
              tbl[i].exp_edge);
      chk_glitch($sformatf("t12 row%0d", i), tbl[i].exp_glitch);
    end

    // Test 3: 2-cycle half-period toggling never commits; each high pulse is one glitch.
    for (int i = 0; i < 32; i++) begin
      y_in = ((i / 2) % 2) == 0;
      tick();
      chk_out($sformatf("t3 cyc%0d", i), 1'b0, 1'b0, 1'b0, 8'd2);
    end
    y_in = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk_out("t3 settle", 1'b0, 1'b0, 1'b0, 8'd2);
    chk_glitch("t3 settle", 8'd9);

    // Test 4: 256 commits saturate edge_cnt, then clear wins over a same-cycle commit.
    y     = 1'b0;
    model = 8'd2;
    for (int c = 0; c < 256; c++) begin
      y    = ~y;
      y_in = y;
      for (int k = 0; k < 5; k++) tick();
      chk($sformatf("t4 c%0d pre y_filt", c), {7'd0, y_filt}, {7'd0, ~y});
      tick();
      model = (model == 8'hff) ? 8'hff : model + 8'd1;
      chk($sformatf("t4 c%0d y_filt", c), {7'd0, y_filt}, {7'd0, y});
      chk($sformatf("t4 c%0d edge_cnt", c), edge_cnt, model);
    end
    chk("t4 saturated", edge_cnt, 8'd255);
    y_in = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk_out("t4 clr", 1'b1, 1'b1, 1'b0, 8'd0);
    chk_glitch("t4 clr", 8'd0);

    // Test 5: reset mid-qualify discards the pending change.
    y_in = 1'b0;
    for (int k = 0; k < 6; k++) tick();
    chk_out("t5 prep", 1'b0, 1'b0, 1'b1, 8'd1);
    y_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    #2 reset = 1'b1;
    #1;
    chk_out("t5 in reset", 1'b0, 1'b0, 1'b0, 8'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk_out($sformatf("t5 edge%0d", k), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    chk_out("t5 edge6", 1'b1, 1'b1, 1'b0, 8'd1);

    // Test 6: disabled filter holds y_filt; enabling commits on the 4th enabled edge.
    en   = 1'b0;
    y_in = 1'b1;
    #2 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk_out($sformatf("t6 dis%0d", k), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    en = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk_out($sformatf("t6 en%0d", k), 1'b0, 1'b0, 1'b0, 8'd0);
    end
    tick();
    chk_out("t6 en4", 1'b1, 1'b1, 1'b0, 8'd1);
    tick();
    chk_out("t6 en5", 1'b1, 1'b0, 1'b0, 8'd1);

    // Dropping en during qualify aborts without a glitch event.
    y_in = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    en   = 1'b0;
    y_in = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_out($sformatf("t6 abort%0d", k), 1'b1, 1'b0, 1'b0, 8'd1);
    end
    en = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    chk_out("t6 after abort", 1'b1, 1'b0, 1'b0, 8'd1);
    chk_glitch("t6 after abort", 8'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
